// File: rtl/ram_word_streamer.sv
// ram_word_streamer: streams words from a 128x32 RAM out as bytes, MSB first.
// Ports: clk, rst (sync, active-high); start/base_addr/word_count request;
//   busy/done status; ram_en/ram_action/ram_addr/ram_rdata RAM read port;
//   tx_data/tx_valid/tx_ready byte handshake toward the transmitter.
// Option: define RAM_STREAMER_CHECKSUM_EN to append an XOR checksum byte.
module ram_word_streamer #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic              ram_action,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_SEND,
`ifdef RAM_STREAMER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_e;

    localparam logic [CNT_W-1:0]  MAX_WORDS = CNT_W'(2 ** ADDR_W);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    words_q;
    logic [1:0]          byte_q;
    logic [DATA_W-1:0]   shreg_q;
    logic                busy_q;
    logic                done_q;
    logic                ram_en_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [7:0]          tx_data_q;
    logic                tx_valid_q;
    logic [CNT_W-1:0]    words_d;
    logic [ADDR_W-1:0]   addr_d;
`ifdef RAM_STREAMER_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    // Requests above the RAM depth are trimmed to one full pass.
    assign words_d = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
    assign addr_d  = addr_q + ADDR_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            words_q    <= '0;
            byte_q     <= '0;
            shreg_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_addr_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
`ifdef RAM_STREAMER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q  <= base_addr;
                        words_q <= words_d;
                        byte_q  <= '0;
                        busy_q  <= 1'b1;
`ifdef RAM_STREAMER_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                        if (word_count == '0) begin
`ifdef RAM_STREAMER_CHECKSUM_EN
                            state_q    <= S_CSUM;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= '0;
`else
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
`endif
                        end else begin
                            state_q    <= S_RD_REQ;
                            ram_en_q   <= 1'b1;
                            ram_addr_q <= base_addr;
                        end
                    end
                end
                S_RD_REQ: begin
                    ram_en_q <= 1'b0;
                    state_q  <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    shreg_q    <= ram_rdata;
                    tx_data_q  <= ram_rdata[DATA_W-1 -: 8];
                    tx_valid_q <= 1'b1;
                    state_q    <= S_SEND;
                end
                S_SEND: begin
                    if (tx_ready) begin
`ifdef RAM_STREAMER_CHECKSUM_EN
                        csum_q <= csum_q ^ tx_data_q;
`endif
                        if (byte_q == 2'd3) begin
                            byte_q     <= '0;
                            addr_q     <= addr_d;
                            words_q    <= words_q - CNT_ONE;
                            tx_valid_q <= 1'b0;
                            if (words_q > CNT_ONE) begin
                                state_q    <= S_RD_REQ;
                                ram_en_q   <= 1'b1;
                                ram_addr_q <= addr_d;
                            end else begin
`ifdef RAM_STREAMER_CHECKSUM_EN
                                // Fold in the byte being accepted now.
                                state_q    <= S_CSUM;
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= csum_q ^ tx_data_q;
`else
                                state_q    <= S_DONE;
                                done_q     <= 1'b1;
`endif
                            end
                        end else begin
                            byte_q    <= byte_q + 2'd1;
                            shreg_q   <= shreg_q << 8;
                            tx_data_q <= shreg_q[DATA_W-9 -: 8];
                        end
                    end
                end
`ifdef RAM_STREAMER_CHECKSUM_EN
                S_CSUM: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign ram_en     = ram_en_q;
    assign ram_action = 1'b0;
    assign ram_addr   = ram_addr_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;

endmodule
